// File: rtl/processor_pkg.sv
// Shared widths, A-source encodings, opcodes and the RAM power-up image (GCD program).
package processor_pkg;

   localparam int DW = 8;
   localparam int AW = 5;

   localparam logic [1:0] ASEL_ALU  = 2'b00;
   localparam logic [1:0] ASEL_IN   = 2'b01;
   localparam logic [1:0] ASEL_MEM  = 2'b10;
   localparam logic [1:0] ASEL_ZERO = 2'b11;

   localparam logic [2:0] LOAD  = 3'b000;
   localparam logic [2:0] STORE = 3'b001;
   localparam logic [2:0] ADD   = 3'b010;
   localparam logic [2:0] SUB   = 3'b011;
   localparam logic [2:0] IN    = 3'b100;
   localparam logic [2:0] JZ    = 3'b101;
   localparam logic [2:0] JPOS  = 3'b110;
   localparam logic [2:0] HALT  = 3'b111;

   typedef logic [DW-1:0] ram_image_t [0:(2**AW)-1];

   localparam ram_image_t RAM_INIT = '{
      8'h80, 8'h3E, 8'h80, 8'h3F, 8'h1E, 8'h7F, 8'hB0, 8'hCC,
      8'h1F, 8'h7E, 8'h3F, 8'hC4, 8'h1E, 8'h7F, 8'h3E, 8'hC4,
      8'h1E, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

endpackage

// File: rtl/processor_ram.sv
// 32x8 unified program/data RAM: combinational read, write on rising edge.
// Contents come up holding the program image and are untouched by reset.
module processor_ram
   import processor_pkg::*;
(
   input  logic          Clock,
   input  logic          wr,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(2**AW)-1] = RAM_INIT;

   always_ff @(posedge Clock) begin
      if (wr)
         mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/processor_datapath.sv
// Accumulator datapath (IR, PC, RAM, A, add/sub) stepped by an external controller.
// Every register samples pre-edge values; flags and OUTPUT follow A combinationally.
module processor_datapath
   import processor_pkg::*;
(
   input  logic          Clock,
   input  logic          Reset,
   input  logic          IRload,
   input  logic          JMPmux,
   input  logic          PCload,
   input  logic          Meminst,
   input  logic          MemWr,
   input  logic          Aload,
   input  logic          Sub,
   input  logic [1:0]    Asel,
   input  logic [DW-1:0] INPUT,
   output logic          Aeq0,
   output logic          Apos,
   output logic [2:0]    IR,
   output logic [DW-1:0] OUTPUT
);

   logic [DW-1:0] ir_q;
   logic [DW-1:0] a_q;
   logic [DW-1:0] m;
   logic [DW-1:0] alu;
   logic [DW-1:0] a_mux;
   logic [AW-1:0] pc_q;
   logic [AW-1:0] pc_next;
   logic [AW-1:0] addr;

   assign addr = Meminst ? ir_q[AW-1:0] : pc_q;

   processor_ram u_ram (
      .Clock (Clock),
      .wr    (MemWr),
      .addr  (addr),
      .wdata (a_q),
      .rdata (m)
   );

   // Subtract as A + ~M + 1; carry out is dropped.
   assign alu = a_q + (Sub ? ~m : m) + DW'(Sub);

   always_comb begin
      a_mux = '0;
      case (Asel)
         ASEL_ALU:  a_mux = alu;
         ASEL_IN:   a_mux = INPUT;
         ASEL_MEM:  a_mux = m;
         ASEL_ZERO: a_mux = '0;
         default:   a_mux = '0;
      endcase
   end

   assign pc_next = JMPmux ? ir_q[AW-1:0] : pc_q + AW'(1);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         ir_q <= '0;
         pc_q <= '0;
         a_q  <= '0;
      end else begin
         if (IRload) ir_q <= m;
         if (PCload) pc_q <= pc_next;
         if (Aload)  a_q  <= a_mux;
      end
   end

   assign Aeq0   = (a_q == '0);
   assign Apos   = ~a_q[DW-1] & (a_q != '0);
   assign IR     = ir_q[DW-1:DW-3];
   assign OUTPUT = a_q;

endmodule

// File: tb/tb_processor_datapath.sv
// Scoreboard bench for processor_datapath: expected {IR, OUTPUT, Aeq0, Apos} queued per edge.
module tb_processor_datapath;
   import processor_pkg::*;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic       IRload = 1'b0, JMPmux = 1'b0, PCload = 1'b0, Meminst = 1'b0;
   logic       MemWr = 1'b0, Aload = 1'b0, Sub = 1'b0;
   logic [1:0] Asel = 2'b00;
   logic [7:0] INPUT = 8'h00;
   logic       Aeq0, Apos;
   logic [2:0] IR;
   logic [7:0] OUTPUT;

   int vecs = 0;
   int errs = 0;

   typedef struct {
      string       tag;
      logic [12:0] obs;
   } exp_t;
   exp_t sb[$];

   processor_datapath dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .IRload  (IRload),
      .JMPmux  (JMPmux),
      .PCload  (PCload),
      .Meminst (Meminst),
      .MemWr   (MemWr),
      .Aload   (Aload),
      .Sub     (Sub),
      .Asel    (Asel),
      .INPUT   (INPUT),
      .Aeq0    (Aeq0),
      .Apos    (Apos),
      .IR      (IR),
      .OUTPUT  (OUTPUT)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got IR=%b OUT=%h Aeq0=%b Apos=%b, want IR=%b OUT=%h Aeq0=%b Apos=%b",
                  tag, got[12:10], got[9:2], got[1], got[0], exp[12:10], exp[9:2], exp[1], exp[0]);
      end
   endtask

   // Drive one edge with the strobes already set, then compare against the queued expectation.
   task automatic step(input string tag, input logic [2:0] eir, input logic [7:0] ea);
      exp_t e;
      e.tag = tag;
      e.obs = {eir, ea, (ea == 8'h00), (~ea[7] && ea != 8'h00)};
      sb.push_back(e);
      @(posedge Clock);
      #1;
      e = sb.pop_front();
      check(e.tag, {IR, OUTPUT, Aeq0, Apos}, e.obs);
      Reset = 0; IRload = 0; JMPmux = 0; PCload = 0; Meminst = 0;
      MemWr = 0; Aload = 0; Sub = 0; Asel = ASEL_ALU;
   endtask

   task automatic load_a(input string tag, input logic [7:0] v, input logic [2:0] eir);
      Asel = ASEL_IN; INPUT = v; Aload = 1;
      step(tag, eir, v);
   endtask

   task automatic store_a(input string tag, input logic [2:0] eir, input logic [7:0] ea);
      Meminst = 1; MemWr = 1;
      step(tag, eir, ea);
   endtask

   task automatic alu_op(input string tag, input logic s, input logic [2:0] eir, input logic [7:0] ea);
      Meminst = 1; Asel = ASEL_ALU; Sub = s; Aload = 1;
      step(tag, eir, ea);
   endtask

   task automatic fetch(input string tag, input logic [2:0] eir, input logic [7:0] ea);
      IRload = 1; PCload = 1; JMPmux = 0; Meminst = 0;
      step(tag, eir, ea);
   endtask

   task automatic read_mem(input string tag, input logic mi, input logic [2:0] eir, input logic [7:0] ea);
      Meminst = mi; Asel = ASEL_MEM; Aload = 1;
      step(tag, eir, ea);
   endtask

   initial begin
      @(negedge Clock);
      Reset = 1;
      step("reset", 3'b000, 8'h00);

      load_a("in_a", 8'd10, 3'b000);

      // IR[4:0] = 0 after reset, so Meminst=1 addresses RAM[0]
      load_a("ld5", 8'd5, 3'b000);
      store_a("st5", 3'b000, 8'd5);
      load_a("ld10", 8'd10, 3'b000);
      alu_op("sub_10_5", 1'b1, 3'b000, 8'd5);

      load_a("ld10b", 8'd10, 3'b000);
      store_a("st10", 3'b000, 8'd10);
      load_a("ld100", 8'd100, 3'b000);
      alu_op("add_100_10", 1'b0, 3'b000, 8'd110);

      load_a("ld5b", 8'd5, 3'b000);
      alu_op("sub_neg", 1'b1, 3'b000, 8'hFB);

      // Store and load A together: RAM gets the old A
      Meminst = 1; MemWr = 1; Asel = ASEL_IN; INPUT = 8'h07; Aload = 1;
      step("wr_ld_a", 3'b000, 8'h07);
      read_mem("old_a_in_ram", 1'b1, 3'b000, 8'hFB);

      Asel = ASEL_ZERO; Aload = 1;
      step("asel_zero", 3'b000, 8'h00);

      // Restore RAM[0] to the program image before fetching
      load_a("ld80", 8'h80, 3'b000);
      store_a("st80", 3'b000, 8'h80);

      // Reset wins over load strobes in the same cycle
      Reset = 1; IRload = 1; Asel = ASEL_IN; INPUT = 8'h33; Aload = 1;
      step("reset_override", 3'b000, 8'h00);

      fetch("fetch0", 3'b100, 8'h00);
      fetch("fetch1", 3'b001, 8'h00);
      read_mem("pc_is_2", 1'b0, 3'b001, 8'h80);

      // Jump with simultaneous IR load: PC takes old IR[4:0] = 30, IR takes RAM[2]
      IRload = 1; PCload = 1; JMPmux = 1; Meminst = 0;
      step("jmp_irload", 3'b100, 8'h80);
      fetch("fetch30", 3'b000, 8'h80);
      fetch("fetch31_wrap", 3'b000, 8'h80);
      fetch("fetch0_again", 3'b100, 8'h80);
      read_mem("pc_is_1", 1'b0, 3'b100, 8'h3E);
      read_mem("ir_addr0", 1'b1, 3'b100, 8'h80);

      load_a("ld7f", 8'h7F, 3'b100);
      load_a("ld01", 8'h01, 3'b100);
      load_a("ldff", 8'hFF, 3'b100);

      // IR load and store at same address: IR gets old word, RAM gets A
      load_a("ld55", 8'h55, 3'b100);
      IRload = 1; MemWr = 1; Meminst = 1;
      step("ir_old_word", 3'b100, 8'h55);
      load_a("ld00", 8'h00, 3'b100);
      read_mem("ram_new_word", 1'b1, 3'b100, 8'h55);
      IRload = 1; Meminst = 1;
      step("ir_new_word", 3'b010, 8'h55);

      check("sb_empty", 13'(sb.size()), 13'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
